// File: rtl/video_pkg.sv
// Shared types, default 800x480 timing and total-size helpers for the video output engine.
package video_pkg;

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } lock_state_e;

  // Debug view of the engine: lock state plus the raw timing counters.
  typedef struct packed {
    lock_state_e state;
    logic [15:0] h_cnt;
    logic [15:0] v_cnt;
  } video_dbg_t;

  localparam int DEF_HDISP  = 800;
  localparam int DEF_VDISP  = 480;
  localparam int DEF_HFP    = 40;
  localparam int DEF_HPULSE = 48;
  localparam int DEF_HBP    = 40;
  localparam int DEF_VFP    = 13;
  localparam int DEF_VPULSE = 3;
  localparam int DEF_VBP    = 29;
  localparam int DEF_PIX_W  = 24;

  function automatic int htotal(input int fp, input int pulse, input int bp, input int disp);
    return fp + pulse + bp + disp;
  endfunction

  function automatic int vtotal(input int fp, input int pulse, input int bp, input int disp);
    return fp + pulse + bp + disp;
  endfunction

endpackage

// File: rtl/video_timing_counter.sv
// Horizontal/vertical raster counters with sync, active-area and frame-start decode.
// Line and frame layout: front porch, sync pulse, back porch, display.
module video_timing_counter
  import video_pkg::*;
#(
  parameter int HDISP  = DEF_HDISP,
  parameter int VDISP  = DEF_VDISP,
  parameter int HFP    = DEF_HFP,
  parameter int HPULSE = DEF_HPULSE,
  parameter int HBP    = DEF_HBP,
  parameter int VFP    = DEF_VFP,
  parameter int VPULSE = DEF_VPULSE,
  parameter int VBP    = DEF_VBP,
  localparam int HTOTAL = htotal(HFP, HPULSE, HBP, HDISP),
  localparam int VTOTAL = vtotal(VFP, VPULSE, VBP, VDISP),
  localparam int HW     = $clog2(HTOTAL),
  localparam int VW     = $clog2(VTOTAL)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  output logic [HW-1:0] h_cnt_o,
  output logic [VW-1:0] v_cnt_o,
  output logic          hs_act_o,
  output logic          vs_act_o,
  output logic          active_o,
  output logic          frame_start_o
);

  localparam logic [HW-1:0] H_LAST = HW'(HTOTAL - 1);
  localparam logic [VW-1:0] V_LAST = VW'(VTOTAL - 1);
  localparam logic [HW-1:0] H_PS   = HW'(HFP);
  localparam logic [HW-1:0] H_PE   = HW'(HFP + HPULSE);
  localparam logic [HW-1:0] H_ACT  = HW'(HFP + HPULSE + HBP);
  localparam logic [VW-1:0] V_PS   = VW'(VFP);
  localparam logic [VW-1:0] V_PE   = VW'(VFP + VPULSE);
  localparam logic [VW-1:0] V_ACT  = VW'(VFP + VPULSE + VBP);

  logic [HW-1:0] h_cnt_q, h_cnt_d;
  logic [VW-1:0] v_cnt_q, v_cnt_d;

  always_comb begin
    h_cnt_d = h_cnt_q + 1'b1;
    v_cnt_d = v_cnt_q;
    if (h_cnt_q == H_LAST) begin
      h_cnt_d = '0;
      v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  assign h_cnt_o       = h_cnt_q;
  assign v_cnt_o       = v_cnt_q;
  assign hs_act_o      = (h_cnt_q >= H_PS) && (h_cnt_q < H_PE);
  assign vs_act_o      = (v_cnt_q >= V_PS) && (v_cnt_q < V_PE);
  assign active_o      = (h_cnt_q >= H_ACT) && (v_cnt_q >= V_ACT);
  assign frame_start_o = (h_cnt_q == '0) && (v_cnt_q == '0);

endmodule

// File: rtl/video_stream_out.sv
// Video output engine: raster timing, frame-locked pixel pull, underflow detect and resync.
// Optional VIDEO_TESTPATTERN_EN replaces the fill colour with 8 vertical colour bars.
module video_stream_out
  import video_pkg::*;
#(
  parameter int               HDISP  = DEF_HDISP,
  parameter int               VDISP  = DEF_VDISP,
  parameter int               HFP    = DEF_HFP,
  parameter int               HPULSE = DEF_HPULSE,
  parameter int               HBP    = DEF_HBP,
  parameter int               VFP    = DEF_VFP,
  parameter int               VPULSE = DEF_VPULSE,
  parameter int               VBP    = DEF_VBP,
  parameter logic             HS_POL = 1'b0,
  parameter logic             VS_POL = 1'b0,
  parameter int               PIX_W  = DEF_PIX_W,
  parameter logic [PIX_W-1:0] FILL   = '0
) (
  input  logic             pixel_clk,
  input  logic             pixel_rst,
  input  logic [PIX_W-1:0] pix_data,
  input  logic             pix_valid,
  output logic             pix_ready,
  input  logic             fill_ok,
  output logic             video_hs,
  output logic             video_vs,
  output logic             video_blank,
  output logic [PIX_W-1:0] video_rgb,
  output logic             sof,
  output logic             resync,
  output logic             underflow,
  output video_dbg_t       dbg_o
);

  localparam int HW    = $clog2(htotal(HFP, HPULSE, HBP, HDISP));
  localparam int VW    = $clog2(vtotal(VFP, VPULSE, VBP, VDISP));
  localparam int H_ACT = HFP + HPULSE + HBP;

  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic          hs_act, vs_act, active, frame_start;

  video_timing_counter #(
    .HDISP (HDISP),
    .VDISP (VDISP),
    .HFP   (HFP),
    .HPULSE(HPULSE),
    .HBP   (HBP),
    .VFP   (VFP),
    .VPULSE(VPULSE),
    .VBP   (VBP)
  ) u_timing (
    .clk_i        (pixel_clk),
    .rst_i        (pixel_rst),
    .h_cnt_o      (h_cnt),
    .v_cnt_o      (v_cnt),
    .hs_act_o     (hs_act),
    .vs_act_o     (vs_act),
    .active_o     (active),
    .frame_start_o(frame_start)
  );

  // Handshake: a pixel is consumed in any cycle where pix_ready and pix_valid are both high;
  // pix_valid on its own never consumes. pix_ready low while locked-active means starvation.
  lock_state_e state_q, state_d;
  logic        take, starve;

  assign pix_ready = active && (state_q == LOCKED);
  assign take      = pix_ready && pix_valid;
  assign starve    = pix_ready && !pix_valid;

  // Lock is only acquired at frame origin so the upstream stream stays frame-aligned.
  always_comb begin
    state_d = state_q;
    case (state_q)
      UNLOCKED: if (frame_start && fill_ok) state_d = LOCKED;
      LOCKED:   if (starve) state_d = UNLOCKED;
      default:  state_d = UNLOCKED;
    endcase
  end

  logic [PIX_W-1:0] idle_pix;

`ifdef VIDEO_TESTPATTERN_EN
  logic [HW-1:0] h_off;
  logic [2:0]    bar_sel;

  always_comb begin
    h_off    = h_cnt - HW'(H_ACT);
    bar_sel  = 3'((32'(h_off) * 32'd8) / 32'(HDISP));
    idle_pix = '0;
    for (int i = 0; i < PIX_W / 3; i++) begin
      idle_pix[i]                 = bar_sel[0];
      idle_pix[PIX_W / 3 + i]     = bar_sel[1];
      idle_pix[2 * (PIX_W / 3) + i] = bar_sel[2];
    end
  end
`else
  assign idle_pix = FILL;
`endif

  logic [PIX_W-1:0] rgb_d;

  always_comb begin
    rgb_d = '0;
    if (active) rgb_d = take ? pix_data : idle_pix;
  end

  logic             video_hs_q, video_vs_q, video_blank_q;
  logic [PIX_W-1:0] video_rgb_q;
  logic             sof_q, resync_q, underflow_q;

  always_ff @(posedge pixel_clk) begin
    if (pixel_rst) begin
      state_q       <= UNLOCKED;
      video_hs_q    <= ~HS_POL;
      video_vs_q    <= ~VS_POL;
      video_blank_q <= 1'b0;
      video_rgb_q   <= '0;
      sof_q         <= 1'b0;
      resync_q      <= 1'b0;
      underflow_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      video_hs_q    <= hs_act ? HS_POL : ~HS_POL;
      video_vs_q    <= vs_act ? VS_POL : ~VS_POL;
      video_blank_q <= active;
      video_rgb_q   <= rgb_d;
      sof_q         <= frame_start;
      resync_q      <= starve;
      underflow_q   <= underflow_q | starve;
    end
  end

  assign video_hs    = video_hs_q;
  assign video_vs    = video_vs_q;
  assign video_blank = video_blank_q;
  assign video_rgb   = video_rgb_q;
  assign sof         = sof_q;
  assign resync      = resync_q;
  assign underflow   = underflow_q;

  assign dbg_o = '{state: state_q, h_cnt: 16'(h_cnt), v_cnt: 16'(v_cnt)};

endmodule

// File: tb/tb_video_stream_out.sv
// Bench for video_stream_out: small 8x5 raster scoreboard scenarios plus default-timing sync periods.
module tb_video_stream_out;
  import video_pkg::*;

  localparam int               PW     = 24;
  localparam logic [PW-1:0]    FILL_V = 24'hA55AC3;
  localparam int               OW     = 30;
  localparam int               FRAME  = 40;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          pixel_rst = 1'b1;
  logic [PW-1:0] pix_data  = '0;
  logic          pix_valid = 1'b0;
  logic          fill_ok   = 1'b0;
  logic          pix_ready, video_hs, video_vs, video_blank, sof, resync, underflow;
  logic [PW-1:0] video_rgb;
  video_dbg_t    dbg;

  video_stream_out #(
    .HDISP(4), .VDISP(2), .HFP(1), .HPULSE(2), .HBP(1), .VFP(1), .VPULSE(1), .VBP(1),
    .HS_POL(1'b0), .VS_POL(1'b0), .PIX_W(PW), .FILL(FILL_V)
  ) dut (
    .pixel_clk(clk), .pixel_rst(pixel_rst), .pix_data(pix_data), .pix_valid(pix_valid),
    .pix_ready(pix_ready), .fill_ok(fill_ok), .video_hs(video_hs), .video_vs(video_vs),
    .video_blank(video_blank), .video_rgb(video_rgb), .sof(sof), .resync(resync),
    .underflow(underflow), .dbg_o(dbg)
  );

  logic          rst_b = 1'b1;
  logic [PW-1:0] pix_data_b = '0;
  logic          pix_valid_b = 1'b0, fill_ok_b = 1'b0;
  logic          pix_ready_b, hs_b, vs_b, blank_b, sof_b, resync_b, uf_b;
  logic [PW-1:0] rgb_b;
  video_dbg_t    dbg_b;

  video_stream_out #(.PIX_W(PW)) dut_big (
    .pixel_clk(clk), .pixel_rst(rst_b), .pix_data(pix_data_b), .pix_valid(pix_valid_b),
    .pix_ready(pix_ready_b), .fill_ok(fill_ok_b), .video_hs(hs_b), .video_vs(vs_b),
    .video_blank(blank_b), .video_rgb(rgb_b), .sof(sof_b), .resync(resync_b),
    .underflow(uf_b), .dbg_o(dbg_b)
  );

  // ---------------- checking ----------------
  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
  endtask

  // ---------------- reference model ----------------
  logic [OW-1:0] exp_q[$];
  int            m_n    = 0;
  bit            m_lock = 1'b0;
  bit            m_uf   = 1'b0;
  logic [PW-1:0] m_data = '0;
  int            obs_take, obs_sof, obs_rs;

  function automatic logic [PW-1:0] idle_pix(input int h);
`ifdef VIDEO_TESTPATTERN_EN
    logic [2:0] ib;
    ib = 3'(((h - 4) * 8) / 4);
    return {{8{ib[2]}}, {8{ib[1]}}, {8{ib[0]}}};
`else
    return (h >= 0) ? FILL_V : FILL_V;
`endif
  endfunction

  // One pixel clock: drive inputs, predict registered outputs, compare after the edge.
  task automatic step(input bit rst, input bit fo, input bit pv);
    int            h, v;
    bit            act, rdy, took;
    logic [PW-1:0] e_rgb;
    logic [OW-1:0] e, got;
    h = m_n % 8;
    v = (m_n / 8) % 5;
    pixel_rst = rst;
    fill_ok   = fo;
    pix_valid = pv;
    pix_data  = m_data;
    #1;
    act  = (h >= 4) && (v >= 3);
    rdy  = act && m_lock;
    took = rdy && pv;
    check("pix_ready", pix_ready, rdy);
    check("lock_state", dbg.state, m_lock);
    if (!rst && pix_ready && pix_valid) obs_take++;
    if (rst) begin
      e = {1'b1, 1'b1, 1'b0, 24'h0, 3'b000};
      m_n = 0; m_lock = 1'b0; m_uf = 1'b0;
    end else begin
      e_rgb = !act ? 24'h0 : (took ? m_data : idle_pix(h));
      e = {!((h >= 1) && (h < 3)), !(v == 1), act, e_rgb,
           (h == 0) && (v == 0), rdy && !pv, m_uf | (rdy && !pv)};
      m_uf = m_uf | (rdy && !pv);
      if (!m_lock && h == 0 && v == 0 && fo) m_lock = 1'b1;
      else if (m_lock && rdy && !pv) m_lock = 1'b0;
      if (took) m_data = m_data + 1'b1;
      m_n = (m_n + 1) % FRAME;
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    got = {video_hs, video_vs, video_blank, video_rgb, sof, resync, underflow};
    check("outputs", got, exp_q.pop_front());
    if (sof) obs_sof++;
    if (resync) obs_rs++;
  endtask

  task automatic do_reset();
    pixel_rst = 1'b1; pix_valid = 1'b0; fill_ok = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", {video_hs, video_vs, video_blank, video_rgb, sof, resync, underflow},
          {1'b1, 1'b1, 1'b0, 24'h0, 3'b000});
    check("reset_ready", pix_ready, 1'b0);
    m_n = 0; m_lock = 1'b0; m_uf = 1'b0; m_data = '0;
    obs_take = 0; obs_sof = 0; obs_rs = 0;
  endtask

  typedef struct {
    bit fill0;
    int drop_at;
    int frames;
    int exp_f0_take;
    int exp_take;
    int exp_sof;
    int exp_rs;
    bit exp_uf;
  } scen_t;

  bit big_done = 1'b0;

  // ---------------- small-raster scenarios ----------------
  initial begin
    scen_t tbl[3];
    int    act_idx, h, v;
    bit    fo, pv;
    tbl[0] = '{1'b1, -1, 2, 8, 16, 2, 0, 1'b0};  // steady stream
    tbl[1] = '{1'b0, -1, 3, 0, 16, 3, 0, 1'b0};  // not filled at first frame start
    tbl[2] = '{1'b1,  2, 2, 2, 10, 2, 1, 1'b1};  // starve on 3rd active pixel

    for (int s = 0; s < 3; s++) begin
      do_reset();
      act_idx = 0;
      for (int c = 0; c < tbl[s].frames * FRAME; c++) begin
        h  = c % 8;
        v  = (c / 8) % 5;
        fo = (c < FRAME) ? tbl[s].fill0 : 1'b1;
        pv = 1'b1;
        if (c < FRAME && h >= 4 && v >= 3) begin
          if (act_idx == tbl[s].drop_at) pv = 1'b0;
          act_idx++;
        end
        step(1'b0, fo, pv);
        if (c == FRAME - 1) check("first_frame_takes", obs_take, tbl[s].exp_f0_take);
      end
      check("total_takes", obs_take, tbl[s].exp_take);
      check("sof_count", obs_sof, tbl[s].exp_sof);
      check("resync_count", obs_rs, tbl[s].exp_rs);
      check("underflow_final", underflow, tbl[s].exp_uf);
    end

    // Reset pulsed mid-frame at (h=5, v=3), locked and streaming.
    do_reset();
    for (int c = 0; c < 29; c++) step(1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b0);
    check("midrst_state", dbg.state, UNLOCKED);
    step(1'b0, 1'b1, 1'b1);
    check("midrst_sof_next", sof, 1'b1);
    for (int c = 0; c < FRAME + 4; c++) step(1'b0, 1'b1, 1'b1);
    check("midrst_relock", dbg.state, LOCKED);

    for (int i = 0; i < 20000 && !big_done; i++) @(posedge clk);
    check("big_done", big_done, 1'b1);
    check("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  // ---------------- default 800x480 timing ----------------
  initial begin
    int  cyc, hs_f0, hs_f1, hs_f2, hs_r0, vs_f, vs_r;
    logic prev_hs, prev_vs;
    logic [15:0] v_at_rise, h_at_rise;
    hs_f0 = 0; hs_f1 = 0; hs_f2 = 0; hs_r0 = 0; vs_f = 0; vs_r = 0;
    v_at_rise = '0; h_at_rise = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_b   = 1'b0;
    cyc     = 0;
    prev_hs = hs_b;
    prev_vs = vs_b;
    while (cyc < 16000 && vs_r == 0) begin
      @(posedge clk);
      #1;
      cyc++;
      if (prev_hs && !hs_b) begin
        if (hs_f0 == 0) hs_f0 = cyc;
        else if (hs_f1 == 0) hs_f1 = cyc;
        else if (hs_f2 == 0) hs_f2 = cyc;
      end
      if (!prev_hs && hs_b && hs_r0 == 0) hs_r0 = cyc;
      if (prev_vs && !vs_b && vs_f == 0) vs_f = cyc;
      if (!prev_vs && vs_b && vs_f != 0) begin
        vs_r      = cyc;
        v_at_rise = dbg_b.v_cnt;
        h_at_rise = dbg_b.h_cnt;
      end
      prev_hs = hs_b;
      prev_vs = vs_b;
    end
    check("big_hs_first_fall", hs_f0, 41);
    check("big_hs_period_a", hs_f1 - hs_f0, 928);
    check("big_hs_period_b", hs_f2 - hs_f1, 928);
    check("big_hs_width", hs_r0 - hs_f0, 48);
    check("big_vs_first_fall", vs_f, 13 * 928 + 1);
    check("big_vs_width", vs_r - vs_f, 3 * 928);
    check("big_vcnt_at_vs_rise", v_at_rise, 16);
    check("big_hcnt_at_vs_rise", h_at_rise, 1);
    check("big_no_blank_unlocked_rgb", rgb_b, 24'h0);
    big_done = 1'b1;
  end

endmodule

// File: doc/video_stream_out.md
# video_stream_out

Parametrised video output engine for the pixel clock domain. It generates programmable-polarity HS/VS/BLANK timing and pulls pixels from an upstream stream (normally the read side of the frame-buffer FIFO) only during the active area. It locks the stream to frame boundaries, detects underflow, and re-synchronises at the next frame. It supersedes the fixed 800x480 controller and drives the video interface pins directly.

## Interface
- HDISP, 800, active pixels per line
- VDISP, 480, active lines per frame
- HFP / HPULSE / HBP, 40 / 48 / 40, horizontal front porch, sync width, back porch (pixels)
- VFP / VPULSE / VBP, 13 / 3 / 29, vertical front porch, sync width, back porch (lines)
- HS_POL / VS_POL, 0 / 0, sync level while asserted (0 = active-low)
- PIX_W, 24, pixel width
- FILL, 0, pixel value driven on underflow or while unlocked
- pixel_clk  in  1  pixel clock; single clock of the block
- pixel_rst  in  1  reset, synchronous, active-high
- pix_data  in  PIX_W  upstream pixel
- pix_valid  in  1  upstream pixel available
- pix_ready  out  1  pixel consumed this cycle when pix_valid is also high
- fill_ok  in  1  upstream pre-filled; sampled only at frame start
- video_hs / video_vs  out  1  sync outputs
- video_blank  out  1  1 = active display (pixel valid on pins), 0 = blanking
- video_rgb  out  PIX_W  pixel output
- sof  out  1  one-cycle pulse aligned with the first output cycle of each frame
- resync  out  1  one-cycle pulse when lock is lost; upstream restarts at frame origin
- underflow  out  1  sticky; cleared only by reset

## Operation
- HTOTAL = HFP+HPULSE+HBP+HDISP and VTOTAL = VFP+VPULSE+VBP+VDISP.
- h_cnt counts 0..HTOTAL-1 and wraps. On wrap, v_cnt increments, wrapping at VTOTAL-1. Counter widths are $clog2(HTOTAL) and $clog2(VTOTAL).
- Line layout: FP, PULSE, BP, DISP. Frame layout is the same.
- HS is asserted for h_cnt in [HFP, HFP+HPULSE). VS is asserted for v_cnt in [VFP, VFP+VPULSE).
- active = (h_cnt >= HFP+HPULSE+HBP) && (v_cnt >= VFP+VPULSE+VBP).
- Frame start is h_cnt==0 && v_cnt==0.
- Lock FSM, two states:
  - UNLOCKED -> LOCKED at frame start if fill_ok=1.
  - LOCKED -> UNLOCKED on underflow (pix_ready && !pix_valid). resync pulses and the underflow flag sets.
- pix_ready = active && LOCKED. It is combinational from the counters and state. It goes low on the cycle after an underflow and stays low until relock.
- Output pixel:
  - pix_data when pix_ready && pix_valid.
  - Otherwise FILL, or the test pattern (see Configuration).
  - Blanking cycles drive 0.
- Simultaneous frame start and fill_ok=0: the block stays UNLOCKED for the whole frame and does not retry mid-frame.
- pix_valid outside pix_ready is ignored and nothing is consumed.

## Timing
- All outputs are registered. Each reflects the counter state of the previous cycle, a 1-cycle latency.
- The first counter state after reset deassert is (0,0). sof pulses in the following cycle.
- Reset values:
  - h_cnt = v_cnt = 0
  - video_hs = ~HS_POL, video_vs = ~VS_POL
  - video_blank = 0, video_rgb = 0
  - sof = resync = underflow = 0
  - state UNLOCKED
- pix_ready is not registered. The consume happens in the same cycle as the counter state, and the pixel appears on video_rgb one cycle later, together with video_blank=1.
- Reset asserted mid-frame: every output takes its reset value on the next edge, and the frame restarts from (0,0).

## Configuration
- VIDEO_TESTPATTERN_EN defined: on underflow or unlocked active cycles, video_rgb shows 8 vertical colour bars instead of FILL.
  - Bar index = (h_cnt - active start) * 8 / HDISP.
  - Colour bits {R,G,B} = index[2], index[1], index[0], each replicated to PIX_W/3 bits.
- VIDEO_TESTPATTERN_EN undefined: FILL is used. No pattern logic is synthesised.

## Structure
- Package video_pkg holds:
  - lock state enum (UNLOCKED, LOCKED)
  - functions htotal()/vtotal() taking porch parameters
  - default 800x480 timing constants
- Sub-module video_timing_counter contains the h/v counters, sync and active decode, and the frame-start strobe.
- The top level holds the lock FSM, the handshake, the output registers and the optional pattern.

## Test plan
Small configuration for all scenarios except the last: HDISP=4, VDISP=2, HFP=1, HPULSE=2, HBP=1, VFP=1, VPULSE=1, VBP=1, HS_POL=VS_POL=0. This gives HTOTAL=8, VTOTAL=5 and a 40-cycle frame.
- Reset release, fill_ok=1, pix_valid=1 constant:
  - video_hs is 0 for output cycles 2,3 of each line.
  - video_vs is 0 for line 1.
  - video_blank is 1 for 8 cycles per frame (lines 3,4, pixels 4..7).
  - sof has a period of 40 cycles.
- Incrementing pix_data 0,1,2,...: video_rgb shows 0..7 in the active cycles of frame 1; exactly 8 pix_ready&&pix_valid per frame.
- fill_ok=0 at first frame start and 1 later: no pix_ready for 40 cycles; consumption begins the frame after fill_ok is seen at (0,0).
- pix_valid dropped on 3rd active pixel:
  - underflow=1 and one resync pulse.
  - Remaining 6 active cycles show FILL, or bars with the macro.
  - Relock at the next frame start.
- pixel_rst pulsed at h_cnt=5, v_cnt=3: next cycle all outputs hold their reset values, and the next sof comes 1 cycle after reset deassert.
- Default 800x480: the HS period is 928 cycles and the VS period is 525 lines.
